sobel_stream_filter: RTL and testbench

Parametrised, stream-based 3x3 Sobel edge filter with valid/start-of-frame handling, selectable output mode and border suppression. It is the next-generation replacement for the fixed 640x480, 8-bit Sobel stage. It sits between the pixel source (camera/ROM reader) and the display/frame writer. Each cycle it accepts at most one pixel and emits one result per fully interior window.

---
 rtl/sobel_stream_filter.sv | 189 ++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: a window and line-buffer shift chain feed a
// three-stage gradient/magnitude/output pipeline, with interior-only emission.
module sobel_stream_filter #(
    parameter int PIX_W  = 8,
    parameter int OUT_W  = 8,
    parameter int SIZE_X = 640,
    parameter int SIZE_Y = 480
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pin_valid,
    input  logic               pin_sof,
    input  logic [PIX_W-1:0]   pin,
    input  logic [1:0]         mode,
    input  logic [OUT_W+3:0]   thresh,
    output logic               pout_valid,
    output logic               pout_sof,
    output logic               pout_eof,
    output logic [OUT_W-1:0]   pout
);
    localparam int SW = PIX_W + 3;
    localparam int TW = OUT_W + 4;
    localparam int CW = ((SW > TW) ? SW : TW) + 1;
    localparam int XW = $clog2(SIZE_X);
    localparam int YW = $clog2(SIZE_Y);
    localparam int LB = SIZE_X - 3;
    localparam logic [XW-1:0] XMAX = XW'(SIZE_X - 1);
    localparam logic [YW-1:0] YMAX = YW'(SIZE_Y - 1);

    function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [SW-2:0] mag(input logic signed [SW-1:0] d);
        return (SW-1)'(d[SW-1] ? -d : d);
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic [SW-1:0] s);
        logic [CW-1:0] se;
        se = CW'(s);
        return (se > CW'((1 << OUT_W) - 1)) ? '1 : se[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] binarize(input logic [SW-1:0] s,
                                                  input logic [TW-1:0] t);
        return (CW'(s) >= CW'(t)) ? '1 : '0;
    endfunction

    logic [XW-1:0] x_cnt, cur_x, nxt_x;
    logic [YW-1:0] y_cnt, cur_y, nxt_y;
    logic          frame_start, interior, first_c, last_c;
    logic [1:0]    mode_frm;
    logic [TW-1:0] thr_frm;

    logic [PIX_W-1:0] r00, r01, r02, r10, r11, r12, r20, r21, r22;
    logic [PIX_W-1:0] lb0 [LB];
    logic [PIX_W-1:0] lb1 [LB];

    logic vld_p0, sof_p0, eof_p0, vld_p1, sof_p1, eof_p1, vld_p2, sof_p2, eof_p2;
    logic [1:0]    mode_p0, mode_p1, mode_p2;
    logic [TW-1:0] thr_p0, thr_p1, thr_p2;

    logic signed [SW-1:0] h_c, v_c, h_p1, v_p1;
    logic [SW-2:0]        ah_p2, av_p2;
    logic [SW-1:0]        sum_c;
    logic [OUT_W-1:0]     res_c;

    // A pin_sof pixel is (0,0) regardless of where the counters stand
    always_comb begin
        cur_x = pin_sof ? '0 : x_cnt;
        cur_y = pin_sof ? '0 : y_cnt;
        nxt_x = cur_x + XW'(1);
        nxt_y = cur_y;
        if (cur_x == XMAX) begin
            nxt_x = '0;
            nxt_y = (cur_y == YMAX) ? '0 : cur_y + YW'(1);
        end
        frame_start = (cur_x == '0) && (cur_y == '0);
        interior    = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
        first_c     = (cur_x == XW'(2)) && (cur_y == YW'(2));
        last_c      = (cur_x == XMAX) && (cur_y == YMAX);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            mode_frm   <= 2'b00;
            thr_frm    <= '0;
            vld_p0     <= 1'b0;
            sof_p0     <= 1'b0;
            eof_p0     <= 1'b0;
            mode_p0    <= 2'b00;
            thr_p0     <= '0;
            vld_p1     <= 1'b0;
            sof_p1     <= 1'b0;
            eof_p1     <= 1'b0;
            mode_p1    <= 2'b00;
            thr_p1     <= '0;
            vld_p2     <= 1'b0;
            sof_p2     <= 1'b0;
            eof_p2     <= 1'b0;
            mode_p2    <= 2'b00;
            thr_p2     <= '0;
            pout_valid <= 1'b0;
            pout_sof   <= 1'b0;
            pout_eof   <= 1'b0;
            pout       <= '0;
        end else begin
            // window load: launch tags and the frame settings in force
            vld_p0  <= pin_valid && interior;
            sof_p0  <= pin_valid && first_c;
            eof_p0  <= pin_valid && last_c;
            mode_p0 <= mode_frm;
            thr_p0  <= thr_frm;
            if (pin_valid) begin
                x_cnt <= nxt_x;
                y_cnt <= nxt_y;
                if (frame_start) begin
                    mode_frm <= mode;
                    thr_frm  <= thresh;
                end
            end
            // stage 1: gradients
            vld_p1  <= vld_p0;
            sof_p1  <= sof_p0;
            eof_p1  <= eof_p0;
            mode_p1 <= mode_p0;
            thr_p1  <= thr_p0;
            // stage 2: magnitudes
            vld_p2  <= vld_p1;
            sof_p2  <= sof_p1;
            eof_p2  <= eof_p1;
            mode_p2 <= mode_p1;
            thr_p2  <= thr_p1;
            // stage 3: output select
            pout_valid <= vld_p2;
            pout_sof   <= sof_p2;
            pout_eof   <= eof_p2;
            if (vld_p2) pout <= res_c;
        end
    end

    // Row 2 is the newest line, column 2 the newest pixel in each row
    always_ff @(posedge clock) begin
        if (pin_valid) begin
            r22 <= pin;
            r21 <= r22;
            r20 <= r21;
            lb1[0] <= r20;
            for (int i = 1; i < LB; i++) lb1[i] <= lb1[i-1];
            r12 <= lb1[LB-1];
            r11 <= r12;
            r10 <= r11;
            lb0[0] <= r10;
            for (int i = 1; i < LB; i++) lb0[i] <= lb0[i-1];
            r02 <= lb0[LB-1];
            r01 <= r02;
            r00 <= r01;
        end
    end

    always_comb begin
        h_c = (ext(r02) + (ext(r12) <<< 1) + ext(r22))
            - (ext(r00) + (ext(r10) <<< 1) + ext(r20));
        v_c = (ext(r20) + (ext(r21) <<< 1) + ext(r22))
            - (ext(r00) + (ext(r01) <<< 1) + ext(r02));
    end

    always_ff @(posedge clock) begin
        // stage 1: gradients
        h_p1  <= h_c;
        v_p1  <= v_c;
        // stage 2: magnitudes
        ah_p2 <= mag(h_p1);
        av_p2 <= mag(v_p1);
    end

    always_comb begin
        sum_c = {1'b0, ah_p2} + {1'b0, av_p2};
        case (mode_p2)
            2'b00:   res_c = sat(sum_c);
            2'b01:   res_c = sat({1'b0, ah_p2});
            2'b10:   res_c = sat({1'b0, av_p2});
            default: res_c = binarize(sum_c, thr_p2);
        endcase
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter on an 8x6 frame: per-scenario tasks compare the
// captured result stream against a direct image-domain Sobel model.
module tb_sobel_stream_filter;
    localparam int SX = 8;
    localparam int SY = 6;
    localparam int PW = 8;
    localparam int OW = 8;

    typedef logic [OW+1:0] res_t;

    logic          clock;
    logic          reset_n;
    logic          pin_valid;
    logic          pin_sof;
    logic [PW-1:0] pin;
    logic [1:0]    mode;
    logic [OW+3:0] thresh;
    logic          pout_valid;
    logic          pout_sof;
    logic          pout_eof;
    logic [OW-1:0] pout;

    sobel_stream_filter #(.PIX_W(PW), .OUT_W(OW), .SIZE_X(SX), .SIZE_Y(SY)) dut (
        .clock(clock), .reset_n(reset_n), .pin_valid(pin_valid), .pin_sof(pin_sof),
        .pin(pin), .mode(mode), .thresh(thresh), .pout_valid(pout_valid),
        .pout_sof(pout_sof), .pout_eof(pout_eof), .pout(pout)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   launch_cyc = 0;
    int   frame_img [SY][SX];
    res_t exp_q[$];
    res_t got_q[$];
    int   got_cyc[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pout_valid) begin
            got_q.push_back({pout_sof, pout_eof, pout});
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: Sobel evaluated directly on the stored image, centres in raster order
    function automatic void model_frame(input logic [1:0] m, input int th);
        int h, v, ah, av, s, val;
        for (int cy = 1; cy <= SY - 2; cy++) begin
            for (int cx = 1; cx <= SX - 2; cx++) begin
                h = (frame_img[cy-1][cx+1] + 2 * frame_img[cy][cx+1] + frame_img[cy+1][cx+1])
                  - (frame_img[cy-1][cx-1] + 2 * frame_img[cy][cx-1] + frame_img[cy+1][cx-1]);
                v = (frame_img[cy+1][cx-1] + 2 * frame_img[cy+1][cx] + frame_img[cy+1][cx+1])
                  - (frame_img[cy-1][cx-1] + 2 * frame_img[cy-1][cx] + frame_img[cy-1][cx+1]);
                ah = (h < 0) ? -h : h;
                av = (v < 0) ? -v : v;
                s  = ah + av;
                case (m)
                    2'b00:   val = (s > 255) ? 255 : s;
                    2'b01:   val = (ah > 255) ? 255 : ah;
                    2'b10:   val = (av > 255) ? 255 : av;
                    default: val = (s >= th) ? 255 : 0;
                endcase
                exp_q.push_back({(cy == 1 && cx == 1), (cy == SY - 2 && cx == SX - 2), OW'(val)});
            end
        end
    endfunction

    task automatic send_pixels(input int n, input int gap_max, input logic [1:0] m,
                               input int th, input logic [1:0] m_mid, input bit use_sof);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                pin_valid = 1'b0;
                pin_sof   = 1'b0;
                tick();
            end
            pin_valid = 1'b1;
            pin       = PW'(frame_img[i / SX][i % SX]);
            pin_sof   = (i == 0) && use_sof;
            if (i == 0) begin
                mode   = m;
                thresh = 12'(th);
            end else begin
                mode   = m_mid;
                thresh = 12'($urandom);
            end
            tick();
            if (i == 2 * SX + 2) launch_cyc = cyc;
        end
        pin_valid = 1'b0;
        pin_sof   = 1'b0;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic fill_flat(input int val);
        for (int y = 0; y < SY; y++) for (int x = 0; x < SX; x++) frame_img[y][x] = val;
    endtask

    task automatic fill_vedge();
        for (int y = 0; y < SY; y++) for (int x = 0; x < SX; x++) frame_img[y][x] = (x >= 4) ? 255 : 0;
    endtask

    task automatic fill_hsteps();
        for (int y = 0; y < SY; y++) for (int x = 0; x < SX; x++) frame_img[y][x] = (y >= 3) ? 10 : 0;
    endtask

    task automatic fill_random();
        for (int y = 0; y < SY; y++) for (int x = 0; x < SX; x++) frame_img[y][x] = int'($urandom_range(255, 0));
    endtask

    task automatic test_reset();
        vectors++;
        if (pout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", pout_valid); end
        vectors++;
        if (pout_sof !== 1'b0) begin miscompares++; $display("FAIL reset_sof: got %b expected 0", pout_sof); end
        vectors++;
        if (pout_eof !== 1'b0) begin miscompares++; $display("FAIL reset_eof: got %b expected 0", pout_eof); end
        vectors++;
        if (pout !== '0) begin miscompares++; $display("FAIL reset_pout: got %h expected 00", pout); end
    endtask

    task automatic test_flat();
        clear_q();
        fill_flat(100);
        model_frame(2'b00, 0);
        send_pixels(SX * SY, 0, 2'b00, 0, 2'b11, 1'b1);
        repeat (6) tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL flat_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL flat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        vectors++;
        if (got_cyc.size() == 0 || got_cyc[0] - launch_cyc != 3) begin
            miscompares++;
            $display("FAIL flat_latency: got %0d expected 3", (got_cyc.size() == 0) ? -1 : got_cyc[0] - launch_cyc);
        end
    endtask

    task automatic test_vertical_edge();
        clear_q();
        fill_vedge();
        model_frame(2'b01, 0);
        model_frame(2'b10, 0);
        send_pixels(SX * SY, 0, 2'b01, 0, 2'b00, 1'b1);
        send_pixels(SX * SY, 0, 2'b10, 0, 2'b01, 1'b1);
        repeat (6) tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL vedge_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL vedge[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_threshold();
        clear_q();
        fill_hsteps();
        model_frame(2'b11, 40);
        model_frame(2'b11, 41);
        send_pixels(SX * SY, 0, 2'b11, 40, 2'b00, 1'b1);
        send_pixels(SX * SY, 0, 2'b11, 41, 2'b01, 1'b1);
        repeat (6) tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL thresh_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL thresh[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_gaps();
        clear_q();
        fill_vedge();
        model_frame(2'b01, 0);
        send_pixels(SX * SY, 5, 2'b01, 0, 2'b10, 1'b1);
        repeat (6) tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL gaps_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL gaps[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_restart();
        clear_q();
        fill_random();
        model_frame(2'b01, 0);
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        send_pixels(20, 0, 2'b01, 0, 2'b11, 1'b1);
        fill_random();
        model_frame(2'b00, 0);
        send_pixels(SX * SY, 2, 2'b00, 0, 2'b10, 1'b1);
        repeat (6) tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL restart_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL restart[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        fill_random();
        model_frame(2'b10, 0);
        model_frame(2'b00, 0);
        send_pixels(SX * SY, 0, 2'b10, 0, 2'b01, 1'b1);
        send_pixels(SX * SY, 0, 2'b00, 0, 2'b11, 1'b0);
        repeat (6) tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            logic [1:0] m;
            int th;
            clear_q();
            fill_random();
            m  = 2'($urandom);
            th = int'($urandom_range(2100, 0));
            model_frame(m, th);
            send_pixels(SX * SY, 3, m, th, 2'($urandom), 1'b1);
            repeat (6) tick();
            vectors++;
            if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_count: got %0d expected %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d[%0d]: got %h expected %h", f, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        fill_random();
        send_pixels(22, 0, 2'b00, 0, 2'b00, 1'b1);
        vectors++;
        if (pout_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_burst: got %b expected 1", pout_valid); end
        #2 reset_n = 1'b0;
        #1;
        test_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        clear_q();
        fill_flat(100);
        model_frame(2'b00, 0);
        send_pixels(SX * SY, 0, 2'b00, 0, 2'b01, 1'b1);
        repeat (6) tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midrst_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midrst[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        vectors++;
        if (got_cyc.size() == 0 || got_cyc[0] - launch_cyc != 3) begin
            miscompares++;
            $display("FAIL midrst_latency: got %0d expected 3", (got_cyc.size() == 0) ? -1 : got_cyc[0] - launch_cyc);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        pin_valid = 1'b0;
        pin_sof   = 1'b0;
        pin       = '0;
        mode      = 2'b00;
        thresh    = '0;
        repeat (3) tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_flat();
        test_vertical_edge();
        test_threshold();
        test_gaps();
        test_restart();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
